// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and constants for the vector reduction unit
//
// Purpose: reduction opcode and FSM state encodings, default lane count.
// Ports: none (package).

package vec_pkg;

  localparam int ELEMENT = 16;

  // 3'b110 and 3'b111 are reserved and have no enumerator
  typedef enum logic [2:0] {
    OP_SUM = 3'b000,
    OP_MAX = 3'b001,
    OP_MIN = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101
  } red_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } red_state_t;

endpackage

// File: rtl/reduce_step.sv
// rtl/reduce_step.sv - one combinational fold step of the reduction
//
// Purpose: folds one lane into the accumulator with the selected operation.
// Ports:
//   i_acc  [W-1:0] current accumulator
//   i_lane [W-1:0] lane being folded in
//   i_op   [2:0]   reduction opcode (red_op_t encoding)
//   o_acc  [W-1:0] next accumulator value
//   o_ovf          signed overflow of this step (SUM only)

module reduce_step
  import vec_pkg::*;
#(
  parameter int W = ELEMENT
) (
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_lane,
  input  logic [2:0]   i_op,
  output logic [W-1:0] o_acc,
  output logic         o_ovf
);

  logic [W-1:0] w_sum;
  logic         w_acc_ge;

  assign w_sum    = i_acc + i_lane;
  assign w_acc_ge = ($signed(i_acc) >= $signed(i_lane));

  always_comb begin
    o_acc = '0;
    o_ovf = 1'b0;
    case (i_op)
      OP_SUM: begin
        o_acc = w_sum;
        // like-signed operands producing an opposite-signed sum
        o_ovf = (i_acc[W-1] == i_lane[W-1]) && (w_sum[W-1] != i_acc[W-1]);
      end
      OP_MAX:  o_acc = w_acc_ge ? i_acc : i_lane;
      OP_MIN:  o_acc = w_acc_ge ? i_lane : i_acc;
      OP_AND:  o_acc = i_acc & i_lane;
      OP_OR:   o_acc = i_acc | i_lane;
      OP_XOR:  o_acc = i_acc ^ i_lane;
      default: o_acc = '0;
    endcase
  end

endmodule

// File: rtl/vec_reduce.sv
// rtl/vec_reduce.sv - multi-cycle vector-to-scalar reduction unit
//
// Purpose: captures a full vector, folds one lane per cycle into a scalar,
//          and returns the scalar over a valid/ready handshake.
// Ports:
//   clk, rst                     clock, async active-high reset
//   in_valid / in_ready          vector input handshake (ready only in IDLE)
//   vector [element-1:0][element-1:0], op [2:0]   source vector and opcode
//   out_valid / out_ready        result output handshake
//   result [element-1:0]         reduced scalar (0 for reserved op)
//   overflow                     sticky signed overflow (SUM only)

module vec_reduce
  import vec_pkg::*;
#(
  parameter int element = ELEMENT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [element-1:0][element-1:0]   vector,
  input  logic [2:0]                        op,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [element-1:0]                result,
  output logic                              overflow
);

  localparam int IW = (element > 2) ? $clog2(element) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(element - 1);

  red_state_t                     r_state;
  logic [element-1:0][element-1:0] r_vec;
  logic [2:0]                     r_op;
  logic [element-1:0]             r_acc;
  logic [IW-1:0]                  r_idx;
  logic                           r_ovf;
  logic                           r_in_ready;
  logic                           r_out_valid;
  logic [element-1:0]             r_result;
  logic                           r_overflow;

  logic [element-1:0]             w_next_acc;
  logic                           w_step_ovf;
  logic                           w_reserved;

  reduce_step #(.W(element)) u_step (
    .i_acc  (r_acc),
    .i_lane (r_vec[r_idx]),
    .i_op   (r_op),
    .o_acc  (w_next_acc),
    .o_ovf  (w_step_ovf)
  );

  assign w_reserved = r_op[2] & r_op[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_op        <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_vec      <= vector;
            r_op       <= op;
            r_acc      <= vector[0];
            r_idx      <= IW'(1);
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= w_next_acc;
          r_ovf <= r_ovf | w_step_ovf;
          r_idx <= r_idx + IW'(1);
          // result registers load on the final fold so DONE outputs are
          // pure flops and stay frozen under backpressure
          if (r_idx == LAST_IDX) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_reserved ? '0 : w_next_acc;
            r_overflow  <= w_reserved ? 1'b0 : (r_ovf | w_step_ovf);
          end
        end
        ST_DONE: begin
          // no bypass to RUN: a new vector waits for IDLE
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_vec_reduce.sv
// tb/tb_vec_reduce.sv - scoreboard testbench for vec_reduce

module tb_vec_reduce;

  localparam int N = 16;

  typedef struct packed {
    logic [N-1:0] res;
    logic         ovf;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][N-1:0]   vector;
  logic [2:0]            op;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0]          result;
  logic                  overflow;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests;
  int   fails;

  vec_reduce #(.element(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vector    (vector),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever a result handshake is about to complete
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got result %h with no pending expectation", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 32'(result), 32'(mon_e.res));
        check("overflow", 32'(overflow), 32'(mon_e.ovf));
      end
    end
  end

  // called aligned to posedge+1; returns with acceptance edge just passed
  task automatic send(input logic [N-1:0][N-1:0] v, input logic [2:0] o,
                      input logic [N-1:0] er, input logic eo, input bit push,
                      output int waited);
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      if (push) exp_q.push_back('{res: er, ovf: eo});
      vector   = v;
      op       = o;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!out_valid && cnt < 100);
    if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
  endtask

  logic [N-1:0][N-1:0] v;
  int w, lat, g;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; vector = '0; op = 3'b000;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SUM 1..16 = 136, with latency check
    for (int i = 0; i < N; i++) v[i] = N'(i + 1);
    send(v, 3'b000, 16'h0088, 1'b0, 1'b1, w);
    wait_done(lat);
    check("sum_latency", 32'(lat), 32'd15);

    // SUM of 0x7FFF lanes wraps to 0xFFF0 with overflow
    for (int i = 0; i < N; i++) v[i] = 16'h7FFF;
    send(v, 3'b000, 16'hFFF0, 1'b1, 1'b1, w);
    wait_done(lat);

    // signed MAX / MIN
    for (int i = 0; i < N; i++) v[i] = 16'h8000;
    v[9] = 16'hFFFF;
    send(v, 3'b001, 16'hFFFF, 1'b0, 1'b1, w);
    wait_done(lat);
    send(v, 3'b010, 16'h8000, 1'b0, 1'b1, w);
    wait_done(lat);

    // bitwise ops and reserved opcodes on lane i = i
    for (int i = 0; i < N; i++) v[i] = N'(i);
    send(v, 3'b101, 16'h0000, 1'b0, 1'b1, w);
    wait_done(lat);
    send(v, 3'b100, 16'h000F, 1'b0, 1'b1, w);
    wait_done(lat);
    send(v, 3'b011, 16'h0000, 1'b0, 1'b1, w);
    wait_done(lat);
    send(v, 3'b110, 16'h0000, 1'b0, 1'b1, w);
    wait_done(lat);
    send(v, 3'b111, 16'h0000, 1'b0, 1'b1, w);

    // back-to-back throughput: element+1 edges between acceptances
    for (int i = 0; i < N; i++) v[i] = 16'h0001;
    send(v, 3'b000, 16'h0010, 1'b0, 1'b1, w);
    for (int i = 0; i < N; i++) v[i] = 16'h0003;
    send(v, 3'b000, 16'h0030, 1'b0, 1'b1, w);
    check("throughput_edges", 32'(w + 1), 32'd17);
    wait_done(lat);

    // backpressure in DONE
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) v[i] = 16'h0002;
    send(v, 3'b000, 16'h0020, 1'b0, 1'b1, w);
    wait_done(lat);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      for (int i = 0; i < N; i++) vector[i] = N'($urandom);
      op = 3'b001;
      @(posedge clk); #1;
      check("bp_result", 32'(result), 32'h0020);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    // raise ready and offer the next vector together
    for (int i = 0; i < N; i++) v[i] = N'(i * 3 - 20);
    exp_q.push_back('{res: 16'hFFEC, ovf: 1'b0});
    out_ready = 1'b1;
    vector    = v;
    op        = 3'b010;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_done(lat);
    check("bp_next_latency", 32'(lat), 32'd15);

    // asynchronous reset in the 7th RUN cycle
    for (int i = 0; i < N; i++) v[i] = 16'h1234;
    send(v, 3'b000, 16'h0000, 1'b0, 1'b0, w);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) v[i] = 16'h0001;
    send(v, 3'b000, 16'h0010, 1'b0, 1'b1, w);
    wait_done(lat);
    check("post_rst_latency", 32'(lat), 32'd15);

    // drain scoreboard
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
